// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM encodings, nibble width and the operand-width legality check.
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned NIB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand width must split into whole nibbles, and at least two of them.
    function automatic bit width_ok(input int unsigned w);
        return ((w % NIB) == 0) && (w >= 2 * NIB);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_carry_skip_adder.sv
// 4-bit carry-skip adder; the carry bypasses the ripple chain when every
// bit position propagates.
module carry_skip_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum  = p ^ c[3:0];
        cout = (&p) ? cin : c[4];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built by stepping one 4-bit carry-skip adder over the
// operand nibbles, least significant first, with the carry held in a register.
module nibble_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    import nibble_serial_adder_ctrl_pkg::*;

    localparam int unsigned NIBBLES = WIDTH / NIB;
    localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t            state;
    state_t            state_d;
    logic              busy_d;
    logic              done_d;
    logic              accept;
    logic              last;

    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry_r;
    logic [WIDTH-1:0]  acc;

    logic [NIB-1:0]    nib_a;
    logic [NIB-1:0]    nib_b;
    logic [NIB-1:0]    nib_sum;
    logic              nib_cout;
    logic [WIDTH-1:0]  acc_merged;
    logic              ovf_c;

    // Next state and registered status outputs.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (idx == IDXW'(NIBBLES - 1)) begin
                    state_d = DONE;
                    last    = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Current nibble slice and the accumulator with this pass's nibble merged in.
    always_comb begin
        nib_a      = NIB'(a_r >> (NIB * idx));
        nib_b      = NIB'(b_r >> (NIB * idx));
        acc_merged = (acc & ~(WIDTH'({NIB{1'b1}}) << (NIB * idx)))
                   | (WIDTH'(nib_sum) << (NIB * idx));
        ovf_c      = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (acc_merged[WIDTH-1] != a_r[WIDTH-1]);
    end

    carry_skip_adder u_csa (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_r),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Operand capture, per-nibble accumulation and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            acc      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            a_r     <= a;
            b_r     <= op ? ~b : b;
            carry_r <= op ? 1'b1 : cin;
        end else if (state == RUN) begin
            acc     <= acc_merged;
            carry_r <= nib_cout;
            idx     <= idx + IDXW'(1);
            if (last) begin
                sum      <= acc_merged;
                cout     <= nib_cout;
                overflow <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl at WIDTH = 16: vector table,
// multi-cycle corner sequences and a random regression against a scoreboard.
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        res_t         exp;
    } vec_t;

    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;
    int   accepted = 0;
    res_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed range test for overflow, unsigned compare for borrow.
    function automatic res_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
        res_t         r;
        logic [W:0]   u;
        int           sr;
        if (!o) begin
            u      = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
            r.sum  = u[W-1:0];
            r.cout = u[W];
            sr     = int'($signed(x)) + int'($signed(y)) + int'(ci);
        end else begin
            r.sum  = W'(x - y);
            r.cout = (x >= y);
            sr     = int'($signed(x)) - int'($signed(y));
        end
        r.ovf = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
        return r;
    endfunction

    always @(negedge clk) begin
        res_t e;
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with sum %0h, required no done", sum);
            end else begin
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("overflow", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    // Called at a negedge; drives start for one edge and waits for done.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input res_t e, output int lat, output int busy_cyc);
        res_t prev;
        bit   held;
        prev  = {sum, cout, overflow};
        held  = 1'b1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        cin   = ci;
        exp_q.push_back(e);
        accepted++;
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_cyc = busy ? 1 : 0;
        if ({sum, cout, overflow} != prev) held = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
            if (!done && ({sum, cout, overflow} != prev)) held = 1'b0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", lat);
        end
        check("result_held", 32'(held), 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        int   lat;
        int   bcyc;
        int   snap;
        res_t e;
        logic o;
        logic ci;
        logic [W-1:0] x;
        logic [W-1:0] y;

        vecs[0] = '{1'b0, 16'h1234, 16'h1111, 1'b0, '{16'h2345, 1'b0, 1'b0}};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, '{16'hFFFE, 1'b0, 1'b0}};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
        vecs[5] = '{1'b1, 16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
        vecs[6] = '{1'b0, 16'h00FF, 16'h0000, 1'b1, '{16'h0100, 1'b0, 1'b0}};
        vecs[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}};

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp, lat, bcyc);
            check("done_latency", 32'(lat), 32'd4);
            check("busy_cycles", 32'(bcyc), 32'd4);
            @(negedge clk);
        end

        // Back-to-back: start held in the DONE cycle.
        run_op(1'b0, 16'h1234, 16'h1111, 1'b0, '{16'h2345, 1'b0, 1'b0}, lat, bcyc);
        run_op(1'b0, 16'h0F0F, 16'h00F1, 1'b0, '{16'h1000, 1'b0, 1'b0}, lat, bcyc);
        check("b2b_latency", 32'(lat), 32'd4);
        check("b2b_busy_cycles", 32'(bcyc), 32'd4);
        @(negedge clk);

        // start while busy is ignored.
        start = 1'b1; op = 1'b0; a = 16'h0100; b = 16'h0023; cin = 1'b0;
        exp_q.push_back('{16'h0123, 1'b0, 1'b0});
        accepted++;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 16'hFFFF; b = 16'h1234; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("busy_start_done_seen", 32'(done), 32'd1);
        repeat (8) @(negedge clk);

        // Reset two cycles into an operation aborts it.
        start = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        snap = done_cnt;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(snap));
        run_op(1'b1, 16'h0010, 16'h0001, 1'b0, '{16'h000F, 1'b1, 1'b0}, lat, bcyc);
        check("post_abort_latency", 32'(lat), 32'd4);
        @(negedge clk);

        // rst and start together: start is dropped.
        rst = 1'b1; start = 1'b1; op = 1'b0; a = 16'h0001; b = 16'h0001;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check("rst_start_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            o  = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            x  = W'($urandom);
            y  = W'($urandom);
            e  = model(o, x, y, ci);
            run_op(o, x, y, ci, e, lat, bcyc);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("done_count", 32'(done_cnt), 32'(accepted));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
